// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB3 completer with a bank of NUM_REGS read/write registers.
// Each access gets WAIT_CYCLES wait states before pready is asserted.
// Optional feature macro: APB_SLV_PSLVERR_EN. When defined, pslverr flags
// out-of-range addresses. When undefined, pslverr is tied to 0.
module apb_slave_regfile #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int                  IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0]          WAIT_C     = 4'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH:0] NUM_REGS_C = (ADDR_WIDTH + 1)'(NUM_REGS);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    // The register index is paddr itself. Only the low bits are used once the range check has passed.
    assign in_range = ({1'b0, paddr} < NUM_REGS_C);
    assign idx      = IDX_W'(paddr);

    // Completion is decoded combinationally from the registered state and the live bus.
    assign pready = (state == ACCESS) & psel & penable & (cnt == WAIT_C);
    assign prdata = (pready & ~pwrite & in_range) ? regs[idx] : '0;

`ifdef APB_SLV_PSLVERR_EN
    assign pslverr = pready & ~in_range;
`else
    assign pslverr = 1'b0;
`endif

    // State and wait-counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. A setup phase starts ACCESS. A dropped psel or a completion returns to IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                end
            end
            ACCESS: begin
                if (!psel || pready) begin
                    state_nxt = IDLE;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register bank. It is written only on a completing in-range write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regs <= '{default: '0};
        end else if (pready && pwrite && in_range) begin
            regs[idx] <= pwdata;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: scoreboard bench for apb_slave_regfile.
// The bench uses three instances with WAIT_CYCLES = 1, 0 and 3.
// Each instance has its own bus.
// Expected completions are queued when a transfer starts.
// They are checked when pready is seen.
module tb_apb_slave_regfile;

    localparam int NDUT = 3;
    localparam int WAITS [NDUT] = '{1, 0, 3};

    typedef struct {
        int         d;
        logic [7:0] rdata;
        logic       err;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       psel    [NDUT];
    logic       penable [NDUT];
    logic       pwrite  [NDUT];
    logic [7:0] paddr   [NDUT];
    logic [7:0] pwdata  [NDUT];
    logic [7:0] prdata  [NDUT];
    logic       pready  [NDUT];
    logic       pslverr [NDUT];

    logic [7:0] mdl [NDUT][16];
    exp_t       sb [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_done = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    apb_slave_regfile #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_CYCLES(1)) u_dut0 (
        .clk(clk), .rstn(rstn), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0])
    );

    apb_slave_regfile #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rstn(rstn), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1])
    );

    apb_slave_regfile #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REGS(16), .WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .rstn(rstn), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
        .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]), .pready(pready[2]),
        .pslverr(pslverr[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < NDUT; d++)
            for (int r = 0; r < 16; r++)
                mdl[d][r] = 8'h00;
    endtask

    // Full transfer on bus d. It starts just after a rising edge and ends just after the completion edge.
    task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        exp_t got_e;
        bit   oor;
        bit   done;
        int   acc;
        oor     = (addr >= 8'd16);
        e.d     = d;
        e.rdata = (!wr && !oor) ? mdl[d][addr[3:0]] : 8'h00;
`ifdef APB_SLV_PSLVERR_EN
        e.err   = oor;
`else
        e.err   = 1'b0;
`endif
        e.acc   = WAITS[d] + 1;
        sb.push_back(e);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        done = 1'b0;
        acc  = 0;
        for (int n = 1; n <= 20 && !done; n++) begin
            @(negedge clk);
            if (pready[d]) begin
                done = 1'b1;
                acc  = n;
            end
        end
        got_e = sb.pop_front();
        if (!done) begin
            chk("pready_timeout", 32'd0, 32'd1);
        end else begin
            chk("prdata", 32'(prdata[d]), 32'(got_e.rdata));
            chk("pslverr", 32'(pslverr[d]), 32'(got_e.err));
            chk("latency", 32'(acc), 32'(got_e.acc));
            last_done = cyc;
            if (wr && !oor) mdl[d][addr[3:0]] = data;
        end
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic read_all(input int d);
        for (int r = 0; r < 16; r++) xfer(d, 1'b0, 8'(r), 8'h00);
    endtask

    initial begin
        int t0;
        rstn = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
        end
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_pready", 32'(pready[d]), 32'd0);
            chk("rst_prdata", 32'(prdata[d]), 32'd0);
            chk("rst_pslverr", 32'(pslverr[d]), 32'd0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Write then read with one wait state.
        xfer(0, 1'b1, 8'd3, 8'hA5);
        xfer(0, 1'b0, 8'd3, 8'h00);

        // Reset asserted in the middle of a read.
        xfer(0, 1'b1, 8'd5, 8'h3C);
        xfer(0, 1'b0, 8'd5, 8'h00);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'd5;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(negedge clk);
        chk("pre_rst_pready", 32'(pready[0]), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_pready", 32'(pready[0]), 32'd0);
            chk("midrst_prdata", 32'(prdata[0]), 32'd0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        clear_model();
        @(posedge clk); #1;
        xfer(0, 1'b0, 8'd5, 8'h00);
        xfer(0, 1'b0, 8'd3, 8'h00);

        // Zero-wait back-to-back transfers complete every second cycle.
        xfer(1, 1'b1, 8'd1, 8'h11);
        t0 = last_done;
        xfer(1, 1'b1, 8'd2, 8'h22);
        chk("b2b_gap1", 32'(last_done - t0), 32'd2);
        t0 = last_done;
        xfer(1, 1'b0, 8'd1, 8'h00);
        chk("b2b_gap2", 32'(last_done - t0), 32'd2);
        t0 = last_done;
        xfer(1, 1'b0, 8'd2, 8'h00);
        chk("b2b_gap3", 32'(last_done - t0), 32'd2);

        // Out-of-range write. All registers stay unchanged.
        xfer(0, 1'b1, 8'd7, 8'h6E);
        xfer(0, 1'b1, 8'd16, 8'hFF);
        xfer(0, 1'b0, 8'd16, 8'h00);
        xfer(0, 1'b1, 8'd200, 8'hFF);
        read_all(0);

        // Abort after one ACCESS cycle with three wait states.
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'd9; pwdata[2] = 8'h99;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(negedge clk);
        chk("abort_pready", 32'(pready[2]), 32'd0);
        @(posedge clk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_idle_pready", 32'(pready[2]), 32'd0);
        end
        @(posedge clk); #1;
        xfer(2, 1'b0, 8'd9, 8'h00);
        xfer(2, 1'b1, 8'd9, 8'h99);
        xfer(2, 1'b0, 8'd9, 8'h00);

        // penable without a setup phase is ignored.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'd4; pwdata[0] = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("nosetup_pready", 32'(pready[0]), 32'd0);
        end
        @(posedge clk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1;
        read_all(0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
